// File: rtl/instr_encoder_if.sv
// Handshake bundle between the instruction producer, the encoder and the
// instruction-memory writer.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_class;
  logic [4:0]  in_func;
  logic [23:0] in_operand;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;

  // master: the environment driving requests and consuming words
  modport master (
    output in_valid, in_class, in_func, in_operand, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  // slave: the encoder itself
  modport slave (
    input  in_valid, in_class, in_func, in_operand, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs instruction requests into 32-bit words, queues them in a 4-entry FIFO
// and tags each delivered word with an auto-incrementing address.
// Define ENC_LEGALITY_CHECK_EN to drop illegal class/func pairs and count them.
module instr_encoder (
  input  logic           clock,
  input  logic           reset_n,
  instr_encoder_if.slave bus,
  input  logic           addr_load,
  input  logic [7:0]     addr_value,
  output logic [7:0]     err_count
);
  localparam int DEPTH = 4;

  logic [2:0]       count_reg;
  logic [2:0]       count_next;
  logic [1:0]       wr_ptr_reg;
  logic [1:0]       rd_ptr_reg;
  logic [7:0]       addr_reg;
  logic [7:0]       addr_next;
  logic             live_reg;
  logic [31:0]      mem_reg [DEPTH];
  logic [DEPTH-1:0] wr_en;

  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic        push;
  logic        pop;
  logic        word_legal;
  logic [31:0] word;

  assign fifo_full  = (count_reg == 3'(DEPTH));
  assign fifo_empty = (count_reg == 3'd0);
  assign word       = {bus.in_class, bus.in_func, bus.in_operand};

  // live_reg keeps the first edge after reset release free of any transfer
  assign accept = live_reg && bus.in_valid && !fifo_full;
  assign push   = accept && word_legal;
  assign pop    = live_reg && !fifo_empty && bus.out_ready;

`ifdef ENC_LEGALITY_CHECK_EN
  logic [7:0] err_reg;

  function automatic logic is_legal(input logic [2:0] cls, input logic [4:0] fn);
    logic ok;
    ok = 1'b0;
    case (cls)
      3'b001:  ok = fn[4] || (fn inside {5'd0, 5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9});
      3'b100:  ok = (fn == 5'd0) || (fn == 5'd1);
      3'b010:  ok = (fn == 5'd2);
      3'b000:  ok = (fn == 5'd0);
      3'b101:  ok = (fn <= 5'd4);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign word_legal = is_legal(bus.in_class, bus.in_func);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_reg <= 8'd0;
    end else if (accept && !word_legal && (err_reg != 8'hFF)) begin
      err_reg <= err_reg + 8'd1;
    end
  end

  assign err_count = err_reg;
`else
  assign word_legal = 1'b1;
  assign err_count  = 8'd0;
`endif

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 3'd1;
      2'b01:   count_next = count_reg - 3'd1;
      default: count_next = count_reg;
    endcase

    // a load wins over the pop increment; the popped word still leaves
    addr_next = addr_reg;
    if (addr_load) begin
      addr_next = addr_value;
    end else if (pop) begin
      addr_next = addr_reg + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg  <= 3'd0;
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      addr_reg   <= 8'd0;
      live_reg   <= 1'b0;
    end else begin
      live_reg  <= 1'b1;
      count_reg <= count_next;
      addr_reg  <= addr_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 2'd1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 2'd1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_reg == 2'(gi));
    end
  endgenerate

  // storage needs no reset: stale entries are masked by the occupancy count
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        mem_reg[i] <= word;
      end
    end
  end

  assign bus.in_ready  = !fifo_full;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_instr = fifo_empty ? 32'h0 : mem_reg[rd_ptr_reg];
  assign bus.out_addr  = addr_reg;
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL: clock  in  1  single clock for all state, rising edge.
REQ-002 SHALL: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL: in_valid  in  1  producer presents an instruction request.
REQ-004 SHALL: in_ready  out  1  encoder can accept a request; equals !fifo_full.
REQ-005 SHALL: in_class  in  3  instruction type code, placed in bits [31:29].
  - 001 = ALU
  - 100 = memory
  - 010 = constant
  - 000 = nop
  - 101 = control
REQ-006 SHALL: in_func  in  5  function code, placed in bits [28:24].
REQ-007 SHALL: in_operand  in  24  operand field, placed unmodified in bits [23:0].
REQ-008 SHALL: out_valid  out  1  FIFO head holds an encoded word.
REQ-009 SHALL: out_ready  in  1  instruction-memory writer accepts the word.
REQ-010 SHALL: out_instr  out  32  encoded instruction at the FIFO head.
REQ-011 SHALL: out_addr  out  8  instruction-memory address for out_instr.
REQ-012 SHALL: addr_load  in  1  loads addr_value into the address counter.
REQ-013 SHALL: addr_value  in  8  start address.
REQ-014 SHALL: err_count  out  8  saturating count of rejected requests.

Function
REQ-015 SHALL: accept a request on a rising edge where in_valid && in_ready.
REQ-016 SHALL: form the encoded word as {in_class, in_func, in_operand}.
REQ-017 SHALL: treat the following as legal; every other combination is illegal.
  - ALU, func in {00000, 00001, 00011, 00100, 00101, 00110, 01000, 01001, 1xxxx}
  - memory, func in {00000 (load), 00001 (store)}
  - constant, func = 00010 (loadlit)
  - nop, func = 00000
  - control, func in {00000, 00001, 00010, 00011, 00100} (jump, beq, bne, jal, jr)
REQ-018 SHALL: push legal accepted words into a 4-entry FIFO.
REQ-019 SHALL: consume illegal accepted words, never push them, and increment err_count by 1, saturating at 255.
REQ-020 SHALL: raise out_valid no earlier than the edge after the push, with no combinational in-to-out bypass when the FIFO is empty.
REQ-021 SHALL: pop the FIFO and increment out_addr by 1 on an edge where out_valid && out_ready; out_addr wraps 255->0.
REQ-022 SHALL: hold out_instr and out_addr stable while out_valid && !out_ready.
REQ-023 SHALL: when the FIFO is full, deassert in_ready even if a pop occurs in the same cycle; push is re-enabled the cycle after the pop.
REQ-024 SHALL: perform push and pop together in one cycle when the FIFO is neither empty nor full, leaving occupancy unchanged.
REQ-025 SHALL: when addr_load is asserted, set out_addr to addr_value on the next edge; addr_load overrides a simultaneous pop increment, and the popped word is still removed.
REQ-026 SHALL: keep out_instr equal to 32'h0 when the FIFO is empty.

Reset
REQ-027 SHALL: on reset_n low, immediately and asynchronously empty the FIFO, clear out_valid, set in_ready=1, out_addr=0, out_instr=0, err_count=0.
REQ-028 SHALL: discard any word in flight when reset is asserted mid-transfer; the first edge after release performs no push or pop.

Configuration
REQ-029 SHALL: with ENC_LEGALITY_CHECK_EN defined, implement REQ-017 and REQ-019 checking.
REQ-030 SHALL: with ENC_LEGALITY_CHECK_EN undefined, push every accepted word unchanged and tie err_count to 0.

Verification
REQ-031 SHALL: reset; push class=001, func=00101, operand=24'h000123 -> next cycle out_valid=1, out_instr=32'h25000123, out_addr=0.
REQ-032 SHALL: hold out_ready=0 and push 5 legal words -> in_ready=0 after the 4th push; the 5th is not accepted; words pop in order with out_addr 0..3.
REQ-033 SHALL: push class=001, func=00010 and class=110, func=00000 -> nothing pushed; err_count=2; with ENC_LEGALITY_CHECK_EN undefined, both words pushed and err_count=0.
REQ-034 SHALL: addr_load=1, addr_value=8'hFF, then pop 2 words -> out_addr 8'hFF, then 8'h00.
REQ-035 SHALL: apply continuous push and pop with occupancy 2 -> occupancy stays 2 and every word is delivered exactly once.
REQ-036 SHALL: assert reset_n low with 3 words queued -> out_valid=0 and in_ready=1 immediately; err_count=0, out_addr=0.
